// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   CLK_DIV_MIN  smallest legal divisor
//   DIV_DEFAULT  divisor every channel holds after reset (4 => 25 MHz)
//   ch_w()       width of a channel-select field, never narrower than 1 bit
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CLK_DIV_MIN = 2;
    localparam int DIV_DEFAULT = 4;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// ---------------------------------------------------------------------------
// clk_div_multi_if
// Divisor configuration port (valid/ready request with error pulse).
//   cfg_valid  master -> slave  request
//   cfg_ch     master -> slave  target channel
//   cfg_div    master -> slave  requested divisor
//   cfg_ready  slave -> master  addressed channel has no update pending
//   cfg_err    slave -> master  one-cycle pulse, last accepted request was illegal
// ---------------------------------------------------------------------------
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) ();

    localparam int CW = ch_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_div_ch.sv
// ---------------------------------------------------------------------------
// clk_div_ch
// One divider channel: counter, active divisor, shadow divisor, pending flag
// and the registered level/strobe outputs.
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   en_i        run enable; low holds the counter at 0 and outputs low
//   sync_i      forces counter to 0 (phase alignment), applies pending divisor
//   load_i      legal request accepted for this channel this edge
//   load_div_i  divisor carried by that request
//   pending_o   shadow divisor waiting for a period boundary
//   clk_div_o   divided clock level
//   clk_en_o    one-cycle strobe per period
// ---------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic             pending_o,
    output logic             clk_div_o,
    output logic             clk_en_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_div_q, clk_div_d;
    logic             clk_en_q, clk_en_d;
    logic             wrap;

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_div_d = 1'b0;
        clk_en_d  = 1'b0;
        // div_q >= 2 always, so div_q-1 cannot underflow
        wrap      = (cnt_q == div_q - CNT_W'(1));

        if (sync_i || !en_i) begin
            // Idle/aligned channel: no period in flight, so a pending divisor is safe to take now
            cnt_d = '0;
            if (pending_q) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
            end
        end else begin
            cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
            clk_en_d  = wrap;
            clk_div_d = (cnt_q < (div_q >> 1));
            if (wrap && pending_q) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
            end
        end

        // The top only loads when pending is clear, so this never collides with an apply
        // above; a load coinciding with a wrap waits for the following wrap.
        if (load_i) begin
            shadow_d  = load_div_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DIV_DEFAULT);
            shadow_q  <= CNT_W'(DIV_DEFAULT);
            pending_q <= 1'b0;
            clk_div_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_div_q <= clk_div_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign pending_o = pending_q;
    assign clk_div_o = clk_div_q;
    assign clk_en_o  = clk_en_q;

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// N-channel programmable clock divider producing divided levels and
// clock-enable strobes from clk_100Mhz. Divisors are reprogrammable through
// the cfg interface and take effect only at a period boundary.
//   clk_100Mhz    clock
//   Reset         synchronous active-high reset
//   ch_enable     per-channel run enable
//   cfg           configuration port (slave side of clk_div_multi_if)
//   sync_start    phase-align all channels (only with CLK_DIV_SYNC_EN)
//   clk_div_out   divided clock level per channel
//   clk_en_pulse  one-cycle strobe per channel per period
// Optional feature: define CLK_DIV_SYNC_EN to add the sync_start port.
// ---------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic              clk_100Mhz,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] ch_enable,
    clk_div_multi_if.slave    cfg,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_start,
`endif
    output logic [NUM_CH-1:0] clk_div_out,
    output logic [NUM_CH-1:0] clk_en_pulse
);

    localparam int CW = ch_w(NUM_CH);

    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] load;
    logic              cfg_ready_w;
    logic              legal_div;
    logic              accept;
    logic              sync_w;
    logic              err_q, err_d;

`ifdef CLK_DIV_SYNC_EN
    assign sync_w = sync_start;
`else
    assign sync_w = 1'b0;
`endif

    // Out-of-range channels match no ch_hit bit: they read as ready so the
    // request is consumed and flagged rather than stalling the master.
    always_comb begin
        ch_hit      = '0;
        cfg_ready_w = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (cfg.cfg_ch == CW'(i));
            if (ch_hit[i]) begin
                cfg_ready_w = ~pending[i];
            end
        end
    end

    assign legal_div = (cfg.cfg_div >= CNT_W'(CLK_DIV_MIN));
    assign accept    = cfg.cfg_valid & cfg_ready_w;
    assign load      = (accept && legal_div) ? ch_hit : '0;
    assign err_d     = accept & ~(legal_div & (|ch_hit));

    always_ff @(posedge clk_100Mhz) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_w;
    assign cfg.cfg_err   = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clk_i      (clk_100Mhz),
            .rst_i      (Reset),
            .en_i       (ch_enable[i]),
            .sync_i     (sync_w),
            .load_i     (load[i]),
            .load_div_i (cfg.cfg_div),
            .pending_o  (pending[i]),
            .clk_div_o  (clk_div_out[i]),
            .clk_en_o   (clk_en_pulse[i])
        );
    end

endmodule
